// File: rtl/temp_alarm_if.sv
// Bus between the temperature conversion stage / system controller and temp_alarm_monitor.
// master drives samples, thresholds and clears; slave returns alarm state and peak temperature.
interface temp_alarm_if;
  logic [7:0] temp_in;
  logic       temp_valid;
  logic [7:0] warn_th;
  logic [7:0] crit_th;
  logic       max_clr;
  logic [1:0] state;
  logic       warn;
  logic       crit;
  logic       alarm_irq;
  logic [7:0] temp_max;

  modport master (
    output temp_in, temp_valid, warn_th, crit_th, max_clr,
    input  state, warn, crit, alarm_irq, temp_max
  );
  modport slave (
    input  temp_in, temp_valid, warn_th, crit_th, max_clr,
    output state, warn, crit, alarm_irq, temp_max
  );
endinterface

// File: rtl/temp_alarm_monitor.sv
// Debounced NORMAL/WARN/CRIT temperature alarm with release hysteresis and peak tracking.
// Optional TEMP_MON_AVG_EN classifies on a 4-sample moving average (2-cycle decision latency).
module temp_alarm_monitor #(
  parameter int PERSIST = 4,
  parameter int HYST    = 2,
  parameter int CNT_W   = 4
) (
  input logic         clk,
  input logic         rst,
  temp_alarm_if.slave bus
);
  typedef enum logic [1:0] {NORMAL = 2'd0, WARN = 2'd1, CRIT = 2'd2} state_e;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_up_cnt, r_dn_cnt, w_up_nxt, w_dn_nxt;
  logic             r_irq, w_irq_nxt, r_warn, r_crit;
  logic [7:0]       r_max;
  logic [7:0]       w_t;
  logic             w_tv;

`ifdef TEMP_MON_AVG_EN
  // r_win holds the three previous samples; r_nsmp counts them up to 3.
  logic [2:0][7:0] r_win;
  logic [1:0]      r_nsmp;
  logic [7:0]      r_avg;
  logic            r_avg_vld;
  logic [9:0]      w_sum;

  assign w_sum = {2'b00, bus.temp_in} + {2'b00, r_win[0]} + {2'b00, r_win[1]} + {2'b00, r_win[2]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_win     <= '0;
      r_nsmp    <= '0;
      r_avg     <= '0;
      r_avg_vld <= 1'b0;
    end else begin
      r_avg_vld <= bus.temp_valid && (r_nsmp == 2'd3);
      if (bus.temp_valid) begin
        r_win  <= {r_win[1:0], bus.temp_in};
        r_avg  <= w_sum[9:2];
        if (r_nsmp != 2'd3) r_nsmp <= r_nsmp + 2'd1;
      end
    end
  end

  assign w_t  = r_avg;
  assign w_tv = r_avg_vld;
`else
  assign w_t  = bus.temp_in;
  assign w_tv = bus.temp_valid;
`endif

  state_e     w_lvl;
  logic [7:0] w_thr;
  logic [8:0] w_rel;
  logic       w_up_q, w_dn_q;

  always_comb begin
    w_lvl = NORMAL;
    if (w_t >= bus.crit_th)      w_lvl = CRIT;
    else if (w_t >= bus.warn_th) w_lvl = WARN;
  end

  // Release needs thr > HYST; otherwise the saturated release point of 0 can never be undercut.
  assign w_thr  = (r_state == CRIT) ? bus.crit_th : bus.warn_th;
  assign w_rel  = {1'b0, w_thr} - 9'(HYST);
  assign w_up_q = (w_lvl > r_state);
  assign w_dn_q = (r_state != NORMAL) && ({1'b0, w_thr} > 9'(HYST)) && ({1'b0, w_t} < w_rel);

  always_comb begin
    w_state_nxt = r_state;
    w_up_nxt    = r_up_cnt;
    w_dn_nxt    = r_dn_cnt;
    w_irq_nxt   = 1'b0;
    if (w_tv) begin
      if (w_up_q) begin
        w_dn_nxt = '0;
        if (r_up_cnt >= CNT_W'(PERSIST - 1)) begin
          w_state_nxt = w_lvl;
          w_up_nxt    = '0;
          w_irq_nxt   = 1'b1;
        end else begin
          w_up_nxt = r_up_cnt + 1'b1;
        end
      end else if (w_dn_q) begin
        w_up_nxt = '0;
        if (r_dn_cnt >= CNT_W'(PERSIST - 1)) begin
          w_state_nxt = state_e'(r_state - 2'd1);
          w_dn_nxt    = '0;
        end else begin
          w_dn_nxt = r_dn_cnt + 1'b1;
        end
      end else begin
        w_up_nxt = '0;
        w_dn_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= NORMAL;
      r_up_cnt <= '0;
      r_dn_cnt <= '0;
      r_irq    <= 1'b0;
      r_warn   <= 1'b0;
      r_crit   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_up_cnt <= w_up_nxt;
      r_dn_cnt <= w_dn_nxt;
      r_irq    <= w_irq_nxt;
      r_warn   <= (w_state_nxt != NORMAL);
      r_crit   <= (w_state_nxt == CRIT);
    end
  end

  // Peak always follows raw samples, never the averaged compare value.
  always_ff @(posedge clk) begin
    if (!rst)                                        r_max <= '0;
    else if (bus.max_clr && bus.temp_valid)          r_max <= bus.temp_in;
    else if (bus.max_clr)                            r_max <= '0;
    else if (bus.temp_valid && bus.temp_in > r_max)  r_max <= bus.temp_in;
  end

  assign bus.state     = r_state;
  assign bus.warn      = r_warn;
  assign bus.crit      = r_crit;
  assign bus.alarm_irq = r_irq;
  assign bus.temp_max  = r_max;
endmodule

// File: tb/tb_temp_alarm_monitor.sv
// Directed bench for temp_alarm_monitor (default build): cycle table plus corner sequences.
module tb_temp_alarm_monitor;
  logic clk = 1'b0;
  logic rst;
  temp_alarm_if bus ();

  temp_alarm_monitor #(.PERSIST(4), .HYST(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       v;
    logic [7:0] t;
    logic       clr;
    int         st;
    int         irq;
    int         mx;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic rst_n, logic v, logic [7:0] t, logic clr, int st, int irq, int mx);
    vec_t e;
    e.rst_n = rst_n; e.v = v; e.t = t; e.clr = clr; e.st = st; e.irq = irq; e.mx = mx;
    vq.push_back(e);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(logic rst_n, logic v, logic [7:0] t, logic clr);
    @(negedge clk);
    rst = rst_n; bus.temp_valid = v; bus.temp_in = t; bus.max_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, int st, int irq, int mx);
    chk({tag, " state"}, int'(bus.state), st);
    chk({tag, " warn"},  int'(bus.warn),  int'(st >= 1));
    chk({tag, " crit"},  int'(bus.crit),  int'(st == 2));
    chk({tag, " irq"},   int'(bus.alarm_irq), irq);
    chk({tag, " max"},   int'(bus.temp_max), mx);
  endtask

  initial begin
    rst = 1'b0; bus.temp_valid = 1'b0; bus.temp_in = '0; bus.max_clr = 1'b0;
    bus.warn_th = 8'd60; bus.crit_th = 8'd80;

    // reset
    add(0,0,0,0, 0,0,0);  add(0,0,0,0, 0,0,0);
    // 65 x4 -> WARN with irq pulse
    add(1,1,65,0, 0,0,65); add(1,1,65,0, 0,0,65); add(1,1,65,0, 0,0,65);
    add(1,1,65,0, 1,1,65); add(1,0,0,0, 1,0,65);
    // 59 holds WARN (>=58), 57 x4 releases
    for (int i = 0; i < 4; i++) add(1,1,59,0, 1,0,65);
    add(1,1,57,0, 1,0,65); add(1,1,57,0, 1,0,65); add(1,1,57,0, 1,0,65);
    add(1,1,57,0, 0,0,65); add(1,0,0,0, 0,0,65);
    // broken run
    add(1,1,65,0, 0,0,65); add(1,1,65,0, 0,0,65); add(1,1,65,0, 0,0,65);
    add(1,1,50,0, 0,0,65);
    // mixed levels -> CRIT directly
    add(1,1,65,0, 0,0,65); add(1,1,85,0, 0,0,85); add(1,1,65,0, 0,0,85);
    add(1,1,85,0, 2,1,85); add(1,0,0,0, 2,0,85);
    // 77 < 78 x4 -> WARN, then 50 x4 -> NORMAL
    add(1,1,77,0, 2,0,85); add(1,1,77,0, 2,0,85); add(1,1,77,0, 2,0,85);
    add(1,1,77,0, 1,0,85); add(1,0,0,0, 1,0,85);
    add(1,1,50,0, 1,0,85); add(1,1,50,0, 1,0,85); add(1,1,50,0, 1,0,85);
    add(1,1,50,0, 0,0,85);
    // peak register
    add(1,0,0,1, 0,0,0);
    add(1,1,30,0, 0,0,30); add(1,1,90,0, 0,0,90); add(1,1,40,0, 0,0,90);
    add(1,1,20,1, 0,0,20); add(1,0,0,1, 0,0,0);
    // CRIT, reset, full run again
    add(1,1,85,0, 0,0,85); add(1,1,85,0, 0,0,85); add(1,1,85,0, 0,0,85);
    add(1,1,85,0, 2,1,85);
    add(0,0,0,0, 0,0,0);
    add(1,1,85,0, 0,0,85); add(1,1,85,0, 0,0,85); add(1,1,85,0, 0,0,85);
    add(1,1,85,0, 2,1,85); add(1,0,0,0, 2,0,85);

    foreach (vq[i]) begin
      step(vq[i].rst_n, vq[i].v, vq[i].t, vq[i].clr);
      chk_all($sformatf("row%0d", i), vq[i].st, vq[i].irq, vq[i].mx);
    end

    // reset in the middle of a count restarts the persistence run
    step(0,0,0,0);
    chk_all("rst", 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1,1,65,0);
    step(0,0,0,0);
    for (int i = 0; i < 3; i++) step(1,1,65,0);
    chk("midrst 3rd state", int'(bus.state), 0);
    step(1,1,65,0);
    chk("midrst 4th state", int'(bus.state), 1);
    chk("midrst 4th irq", int'(bus.alarm_irq), 1);

    // crit_th wins when warn_th > crit_th
    step(0,0,0,0);
    bus.warn_th = 8'd90; bus.crit_th = 8'd70;
    for (int i = 0; i < 4; i++) step(1,1,75,0);
    chk("prio state", int'(bus.state), 2);
    chk("prio irq", int'(bus.alarm_irq), 1);

    // threshold <= HYST: release impossible
    bus.crit_th = 8'd1;
    for (int i = 0; i < 6; i++) step(1,1,0,0);
    chk("nohyst state", int'(bus.state), 2);
    chk("nohyst irq", int'(bus.alarm_irq), 0);

    // threshold just above HYST: 0 < 3-2 releases one step
    bus.crit_th = 8'd3; bus.warn_th = 8'd200;
    for (int i = 0; i < 3; i++) step(1,1,0,0);
    chk("rel3 hold", int'(bus.state), 2);
    step(1,1,0,0);
    chk("rel3 state", int'(bus.state), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
